ula_arbitro: RTL

- Arbitrates and sequences the shared 8-bit ALU (ULA) between two requesters, e.g. the processor datapath and the game-logic collision/score unit.
- Each requester issues an operation over a valid/ready handshake.
- The block drives the ULA operand and control inputs for one execute cycle, registers the result and zero flag, and returns them over a valid/ready response channel.
- Round-robin fairness; illegal op codes are rejected without being issued to the ULA.

---
 rtl/ula_arbitro.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ula_arbitro.sv
// rtl/ula_arbitro.sv - round-robin arbiter and sequencer for the shared 8-bit ULA
module ula_arbitro #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_flagz,
    output logic             rsp0_err,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_flagz,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] ula_srca,
    output logic [WIDTH-1:0] ula_srcb,
    output logic [OPW-1:0]   ula_ctrl,
    input  logic [WIDTH-1:0] ula_result,
    input  logic             ula_flagz,
    output logic             ocupado
);

    localparam logic [OPW-1:0] OP_AND = OPW'(0);
    localparam logic [OPW-1:0] OP_OR  = OPW'(1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_BNE = OPW'(5);
    localparam logic [OPW-1:0] OP_BEQ = OPW'(6);
    localparam logic [OPW-1:0] OP_SLT = OPW'(7);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [OPW-1:0]   op_q;
    logic             owner_q;
    logic             last_grant;
    logic [WIDTH-1:0] res_q;
    logic             flagz_q;
    logic             err_q;

    logic grant_valid;
    logic grant_id;
    logic accept;
    logic rsp_fire;
    logic op_legal;
    logic op_is_cmp;

    // Grant selection: a lone requester wins outright, contention goes to whoever was not served last.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && grant_valid && !grant_id;
    assign req1_ready = (state == IDLE) && grant_valid &&  grant_id;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign rsp_fire   = (state == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

    // Decode of the latched op: illegal codes never reach the ULA, and the ULA zero flag is only meaningful for compares.
    always_comb begin
        op_legal  = (op_q == OP_AND) || (op_q == OP_OR)  || (op_q == OP_ADD) ||
                    (op_q == OP_BNE) || (op_q == OP_BEQ) || (op_q == OP_SLT);
        op_is_cmp = (op_q == OP_BNE) || (op_q == OP_BEQ);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one-cycle execute, response held until the owner consumes it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = EXEC;
            EXEC:                  state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Request latch, fairness pointer and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            owner_q    <= 1'b0;
            last_grant <= 1'b1;
            res_q      <= '0;
            flagz_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                a_q        <= grant_id ? req1_a  : req0_a;
                b_q        <= grant_id ? req1_b  : req0_b;
                op_q       <= grant_id ? req1_op : req0_op;
                owner_q    <= grant_id;
                last_grant <= grant_id;
            end
            if (state == EXEC) begin
                res_q   <= op_legal ? ula_result : '0;
                flagz_q <= op_legal && op_is_cmp && ula_flagz;
                err_q   <= !op_legal;
            end
        end
    end

    assign ula_srca = ((state == EXEC) && op_legal) ? a_q  : '0;
    assign ula_srcb = ((state == EXEC) && op_legal) ? b_q  : '0;
    assign ula_ctrl = ((state == EXEC) && op_legal) ? op_q : '0;

    assign rsp0_valid  = (state == RESP) && !owner_q;
    assign rsp1_valid  = (state == RESP) &&  owner_q;
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_flagz  = flagz_q;
    assign rsp1_flagz  = flagz_q;
    assign rsp0_err    = err_q;
    assign rsp1_err    = err_q;

    assign ocupado = (state != IDLE);

endmodule
